// File: rtl/md_pkg.sv
// Shared op encodings and decode helpers for the HI/LO multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  // One bit per opcode: set for ops that occupy the unit for multiple cycles.
  localparam logic [15:0] MD_COMPUTE_MASK = 16'h079E;

  function automatic logic is_compute(input logic [3:0] op);
    return MD_COMPUTE_MASK[op];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational datapath: next HI/LO and divide-by-zero flag for one op.
module md_result_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             dz
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               b_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   div_u_den;
  logic [WIDTH-1:0]   div_s_den;
  logic [WIDTH-1:0]   q_u;
  logic [WIDTH-1:0]   r_u;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;

  assign acc    = {hi, lo};
  // Sign-extending to 2*WIDTH makes an unsigned multiply yield the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero = (b == '0);
  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag  = b_neg ? (~b + WIDTH'(1)) : b;

  // Substitute a divisor of 1 when b==0 so the dividers never see zero.
  assign div_u_den = b_zero ? WIDTH'(1) : b;
  assign div_s_den = b_zero ? WIDTH'(1) : b_mag;
  assign q_u   = a / div_u_den;
  assign r_u   = a % div_u_den;
  assign q_mag = a_mag / div_s_den;
  assign r_mag = a_mag % div_s_den;
  // Magnitude division: -2^(W-1) / -1 wraps naturally to -2^(W-1) with remainder 0.
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
  assign r_s   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    hi_next = hi;
    lo_next = lo;
    dz      = 1'b0;
    case (op)
      MD_MULT:  {hi_next, lo_next} = prod_s;
      MD_MULTU: {hi_next, lo_next} = prod_u;
      MD_MADD:  {hi_next, lo_next} = acc + prod_s;
      MD_MADDU: {hi_next, lo_next} = acc + prod_u;
      MD_MSUB:  {hi_next, lo_next} = acc - prod_s;
      MD_MSUBU: {hi_next, lo_next} = acc - prod_u;
      MD_DIV: begin
        if (b_zero) dz = 1'b1;
        else begin
          lo_next = q_s;
          hi_next = r_s;
        end
      end
      MD_DIVU: begin
        if (b_zero) dz = 1'b1;
        else begin
          lo_next = q_u;
          hi_next = r_u;
        end
      end
      MD_MTHI: hi_next = a;
      MD_MTLO: lo_next = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_param.sv
// E-stage HI/LO multiply/divide unit: accepts an op, holds busy for a fixed
// latency, then commits the precomputed result to HI/LO.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_dz;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             dz_next;
  logic             move_ok;

  md_result_calc #(.WIDTH(WIDTH)) u_calc (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .dz      (dz_next)
  );

  assign start   = is_compute(op) && !busy && !flush && !reset;
  assign move_ok = ((op == MD_MTHI) || (op == MD_MTLO)) && !busy && !flush;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      count    <= '0;
      div_zero <= 1'b0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_dz  <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      if (start) begin
        pend_hi <= hi_next;
        pend_lo <= lo_next;
        pend_dz <= dz_next;
        count   <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        busy    <= 1'b1;
      end else if (busy) begin
        if (count == CNT_W'(1)) begin
          hi       <= pend_hi;
          lo       <= pend_lo;
          div_zero <= pend_dz;
          busy     <= 1'b0;
          count    <= '0;
        end else begin
          count <= count - CNT_W'(1);
        end
      end else if (move_ok) begin
        hi <= hi_next;
        lo <= lo_next;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: directed cases plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_md_unit_param;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  logic        reset16;
  logic [3:0]  op16;
  logic        flush16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        start16;
  logic        busy16;
  logic [15:0] hi16;
  logic [15:0] lo16;
  logic        div_zero16;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .op(op), .flush(flush), .a(a), .b(b),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset16), .op(op16), .flush(flush16), .a(a16), .b(b16),
    .start(start16), .busy(busy16), .hi(hi16), .lo(lo16), .div_zero(div_zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle; returns start as seen mid-cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic fl, output logic st);
    op = o; a = x; b = y; flush = fl;
    #1 st = start;
    step();
    op = MD_NONE; flush = 1'b0;
  endtask

  // Count busy cycles remaining (bounded) and div_zero pulses seen while busy.
  task automatic wait_idle(output int n, output int dz_early);
    n = 0; dz_early = 0;
    while (busy === 1'b1 && n < 200) begin
      if (div_zero === 1'b1) dz_early++;
      n++;
      step();
    end
  endtask

  // Reference: wide integer arithmetic straight from the op definitions.
  task automatic ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        inout logic [31:0] rh, inout logic [31:0] rl, output logic dz);
    longint sx, sy, sq, sr;
    logic [63:0] acc, ps, pu, res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    acc = {rh, rl};
    ps  = 64'(sx * sy);
    pu  = {32'b0, x} * {32'b0, y};
    dz  = 1'b0;
    res = acc;
    case (o)
      MD_MULT:  res = ps;
      MD_MULTU: res = pu;
      MD_MADD:  res = acc + ps;
      MD_MADDU: res = acc + pu;
      MD_MSUB:  res = acc - ps;
      MD_MSUBU: res = acc - pu;
      MD_DIV: begin
        if (y == 0) dz = 1'b1;
        else begin
          sq = sx / sy;
          sr = sx % sy;
          res = {32'(sr), 32'(sq)};
        end
      end
      MD_DIVU: begin
        if (y == 0) dz = 1'b1;
        else res = {x % y, x / y};
      end
      MD_MTHI: res = {x, rl};
      MD_MTLO: res = {rh, x};
      default: ;
    endcase
    rh = res[63:32];
    rl = res[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4; flush = 1'b0;
    #1;
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    step(); step();
    op = MD_NONE;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || div_zero !== 0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b dz=%b want all 0", hi, lo, busy, div_zero);
    end
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    logic st; int n, dze;
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (st !== 1'b1 || n != MC) begin
      errors++; $display("FAIL mult_timing: start=%b busy_cycles=%0d want 1/%0d", st, n, MC);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff/fffffffa", hi, lo);
    end
    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA || n != MC) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h cycles=%0d want 00000002/fffffffa/%0d", hi, lo, n, MC);
    end
    m_hi = 32'h2; m_lo = 32'hFFFFFFFA;
  endtask

  task automatic test_div();
    logic st; int n, dze; int pulses;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (st !== 1'b1 || n != DC || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_signed: start=%b cycles=%0d hi=%h lo=%h want 1/%0d/ffffffff/fffffffd", st, n, hi, lo, DC);
    end
    checks++;
    if (div_zero !== 1'b0) begin errors++; $display("FAIL div_no_dz: got %b want 0", div_zero); end
    issue(MD_DIVU, 32'd7, 32'd0, 1'b0, st);
    wait_idle(n, dze);
    pulses = dze;
    checks++;
    if (n != DC || div_zero !== 1'b1) begin
      errors++; $display("FAIL divu_zero_pulse: cycles=%0d dz=%b want %0d/1", n, div_zero, DC);
    end
    step();
    if (div_zero === 1'b1) pulses++;
    checks++;
    if (pulses != 0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL divu_zero_hold: extra_pulses=%0d hi=%h lo=%h want 0/ffffffff/fffffffd", pulses, hi, lo);
    end
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h want 00000000/80000000", hi, lo);
    end
    m_hi = 32'h0; m_lo = 32'h80000000;
  endtask

  task automatic test_mac();
    logic st; int n, dze;
    issue(MD_MTHI, 32'h1, 32'h0, 1'b0, st);
    checks++;
    if (st !== 1'b0 || busy !== 1'b0 || hi !== 32'h1) begin
      errors++; $display("FAIL mthi: start=%b busy=%b hi=%h want 0/0/00000001", st, busy, hi);
    end
    issue(MD_MTLO, 32'h2, 32'h0, 1'b0, st);
    checks++;
    if (lo !== 32'h2 || hi !== 32'h1) begin
      errors++; $display("FAIL mtlo: hi=%h lo=%h want 00000001/00000002", hi, lo);
    end
    issue(MD_MADD, 32'h80000000, 32'd2, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (st !== 1'b1 || n != MC || hi !== 32'h0 || lo !== 32'h2) begin
      errors++; $display("FAIL madd: start=%b cycles=%0d hi=%h lo=%h want 1/%0d/00000000/00000002", st, n, hi, lo, MC);
    end
    issue(MD_MSUBU, 32'd1, 32'd3, 1'b0, st);
    wait_idle(n, dze);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL msubu: hi=%h lo=%h want ffffffff/ffffffff", hi, lo);
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFF;
  endtask

  task automatic test_busy_ignore();
    logic st, st2, st3; int n, dze;
    issue(MD_MULT, 32'd5, 32'd7, 1'b0, st);
    issue(MD_DIV, 32'd100, 32'd3, 1'b0, st2);
    issue(MD_MTLO, 32'hDEAD, 32'd0, 1'b0, st3);
    checks++;
    if (st !== 1'b1 || st2 !== 1'b0 || st3 !== 1'b0) begin
      errors++; $display("FAIL busy_start: mult=%b div=%b mtlo=%b want 1/0/0", st, st2, st3);
    end
    wait_idle(n, dze);
    checks++;
    if (n != MC - 2 || hi !== 32'h0 || lo !== 32'd35) begin
      errors++; $display("FAIL busy_ignore: cycles_left=%0d hi=%h lo=%h want %0d/00000000/00000023", n, hi, lo, MC - 2);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || lo !== 32'd35) begin
      errors++; $display("FAIL busy_no_replay: busy=%b lo=%h want 0/00000023", busy, lo);
    end
    issue(MD_MULT, 32'd9, 32'd9, 1'b1, st);
    checks++;
    if (st !== 1'b0 || busy !== 1'b0 || lo !== 32'd35) begin
      errors++; $display("FAIL flush_mult: start=%b busy=%b lo=%h want 0/0/00000023", st, busy, lo);
    end
    issue(MD_MTHI, 32'h77, 32'd0, 1'b1, st);
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL flush_mthi: hi=%h want 00000000", hi); end
    m_hi = 32'h0; m_lo = 32'd35;
  endtask

  task automatic test_reset_mid();
    logic st; int bad;
    issue(MD_MTHI, 32'h1234, 32'd0, 1'b0, st);
    issue(MD_MTLO, 32'h5678, 32'd0, 1'b0, st);
    issue(MD_DIV, 32'd100, 32'd7, 1'b0, st);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    bad = 0;
    for (int i = 0; i < DC + 4; i++) begin
      if (div_zero !== 1'b0 || hi !== 0 || lo !== 0 || busy !== 0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_after: bad_cycles=%0d want 0", bad); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_param16();
    logic st;
    op16 = MD_MULT; a16 = 16'h8000; b16 = 16'h8000; flush16 = 1'b0;
    #1 st = start16;
    step();
    op16 = MD_NONE;
    checks++;
    if (st !== 1'b1 || busy16 !== 1'b1) begin
      errors++; $display("FAIL w16_accept: start=%b busy=%b want 1/1", st, busy16);
    end
    step();
    checks++;
    if (busy16 !== 1'b0 || hi16 !== 16'h4000 || lo16 !== 16'h0000) begin
      errors++; $display("FAIL w16_mult: busy=%b hi=%h lo=%h want 0/4000/0000", busy16, hi16, lo16);
    end
  endtask

  task automatic test_random();
    logic st, fl, dz, comp;
    logic [3:0] o;
    logic [31:0] x, y;
    int n, dze, want_n;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(1, 10));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20)));
      fl = ($urandom_range(0, 7) == 0);
      comp = (o != MD_MTHI) && (o != MD_MTLO);
      dz = 1'b0;
      if (!fl) ref_op(o, x, y, m_hi, m_lo, dz);
      issue(o, x, y, fl, st);
      checks++;
      if (st !== (comp && !fl)) begin
        errors++; $display("FAIL rnd_start[%0d]: op=%0d flush=%b start=%b want %b", i, o, fl, st, comp && !fl);
      end
      if (comp && !fl) begin
        want_n = (o == MD_DIV || o == MD_DIVU) ? DC : MC;
        wait_idle(n, dze);
        checks++;
        if (n != want_n || div_zero !== dz || dze != 0) begin
          errors++; $display("FAIL rnd_timing[%0d]: op=%0d cycles=%0d dz=%b want %0d/%b", i, o, n, div_zero, want_n, dz);
        end
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL rnd_result[%0d]: op=%0d a=%h b=%h hi=%h lo=%h want %h/%h", i, o, x, y, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    reset = 1'b1; op = MD_NONE; flush = 1'b0; a = '0; b = '0;
    reset16 = 1'b1; op16 = MD_NONE; flush16 = 1'b0; a16 = '0; b16 = '0;
    m_hi = 0; m_lo = 0;
    test_reset();
    reset16 = 1'b0;
    test_mult();
    test_div();
    test_mac();
    test_busy_ignore();
    test_reset_mid();
    test_param16();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
